buffer_arbiter: RTL and testbench



---
 rtl/buffer_pkg.sv | 25 ++
 rtl/rr_pick2.sv | 30 +++
 rtl/buffer_arbiter.sv | 129 ++++++++++++
 tb/tb_buffer_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// ---------------------------------------------------------------------------
// buffer_pkg
// Shared definitions for the serialising buffer and the arbiter in front of
// it: the arbiter state encoding and the default geometry constants that
// the buffer, the arbiter and their benches must agree on.
// No ports (package).
// ---------------------------------------------------------------------------
package buffer_pkg;

  // Default nibble width, matches the buffer's data_in
  localparam int DEF_DATA_W       = 4;
  // Default nibbles loaded per grant
  localparam int DEF_BURST_LEN    = 3;
  // Default idle cycles after the last load while the buffer shifts out
  localparam int DEF_DRAIN_CYCLES = 12;
  // Default drain counter width
  localparam int DEF_CNT_W        = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin chooser.
// Ports:
//   valid0, valid1 : request lines
//   pointer        : preferred requester (0 or 1)
//   grant          : chosen requester, only meaningful when any=1
//   any            : at least one request present
// ---------------------------------------------------------------------------
module rr_pick2 (
  input  logic valid0,
  input  logic valid1,
  input  logic pointer,
  output logic grant,
  output logic any
);

  // The preferred requester wins when it is asking; otherwise the other
  // one gets it. With nothing valid the grant value is a don't-care.
  always_comb begin
    any   = valid0 | valid1;
    grant = pointer;
    if (pointer == 1'b0) begin
      grant = valid0 ? 1'b0 : 1'b1;
    end else begin
      grant = valid1 ? 1'b1 : 1'b0;
    end
  end

endmodule

// File: rtl/buffer_arbiter.sv
// ---------------------------------------------------------------------------
// buffer_arbiter
// Arbitrates two nibble requesters onto the serialising buffer. A granted
// requester owns a whole burst of BURST_LEN nibbles, handed over through a
// valid/ready handshake and re-registered onto buf_ena/buf_data. After the
// burst the arbiter holds off for DRAIN_CYCLES while the buffer shifts out.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   reqN_valid/data/ready   : requester N handshake (N = 0, 1)
//   buf_ena, buf_data       : registered load strobe and nibble to buffer
//   grant_id                : current/last granted requester
//   busy                    : high while loading or draining
//   burst_done              : one-cycle pulse when draining completes
// ---------------------------------------------------------------------------
module buffer_arbiter
  import buffer_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              buf_ena,
  output logic [DATA_W-1:0] buf_data,
  output logic              grant_id,
  output logic              busy,
  output logic              burst_done
);

  localparam logic [3:0]       LAST_BEAT  = 4'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DRAIN_CYCLES - 1);

  arb_state_t        state;
  logic [3:0]        beat_cnt;
  logic [CNT_W-1:0]  drain_cnt;
  logic              pointer;
  logic              pick_grant;
  logic              pick_any;
  logic              granted_valid;
  logic [DATA_W-1:0] granted_data;
  logic              transfer;

  rr_pick2 u_pick (
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .pointer (pointer),
    .grant   (pick_grant),
    .any     (pick_any)
  );

  // Ready is driven straight from the registered state and grant so the
  // requesters see it without any dependence on their own valid lines;
  // the non-granted side simply never sees ready.
  always_comb begin
    req0_ready    = (state == LOAD) && (grant_id == 1'b0);
    req1_ready    = (state == LOAD) && (grant_id == 1'b1);
    granted_valid = grant_id ? req1_valid : req0_valid;
    granted_data  = grant_id ? req1_data  : req0_data;
    transfer      = (state == LOAD) && granted_valid;
  end

  // Single sequential block for the FSM, counters and every registered
  // output. buf_ena and burst_done default low each cycle so they behave
  // as strobes; buf_data only moves on a handshake. busy is updated in the
  // same branch that changes state so it always tracks state != IDLE.
  // The final nibble of a burst shows up on buf_ena during the first DRAIN
  // cycle because of the one-cycle load latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      drain_cnt  <= '0;
      pointer    <= 1'b0;
      buf_ena    <= 1'b0;
      buf_data   <= '0;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      buf_ena    <= 1'b0;
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_grant;
            state    <= LOAD;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (transfer) begin
            buf_ena  <= 1'b1;
            buf_data <= granted_data;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            drain_cnt  <= '0;
            burst_done <= 1'b1;
            pointer    <= ~grant_id;
            state      <= IDLE;
            busy       <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_buffer_arbiter
// Self-checking bench for buffer_arbiter. A behavioural model tracks the
// arbiter as "nibbles still owed", "quiet cycles still to wait" and a
// preferred requester, and predicts every output after each clock edge.
// Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_buffer_arbiter;

  localparam int DATA_W       = 4;
  localparam int BURST_LEN    = 3;
  localparam int DRAIN_CYCLES = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              buf_ena;
  logic [DATA_W-1:0] buf_data;
  logic              grant_id;
  logic              busy;
  logic              burst_done;

  int num_checks = 0;
  int num_fails  = 0;

  // Behavioural model state
  int          m_beats_left = 0;
  int          m_quiet      = 0;
  int          m_prefer     = 0;
  int          m_grant      = 0;
  logic        m_ena        = 1'b0;
  logic        m_done       = 1'b0;
  logic [3:0]  m_data       = 4'h0;

  buffer_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .buf_ena    (buf_ena),
    .buf_data   (buf_data),
    .grant_id   (grant_id),
    .busy       (busy),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it if the values differ (X counts
  // as a difference).
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic modelReady(input int who);
    return (m_beats_left > 0) && (m_grant == who);
  endfunction

  // Advances the model across one clock edge using the inputs now driven.
  task automatic modelStep();
    if (rst) begin
      m_beats_left = 0;
      m_quiet      = 0;
      m_prefer     = 0;
      m_grant      = 0;
      m_ena        = 1'b0;
      m_done       = 1'b0;
      m_data       = 4'h0;
    end else begin
      m_ena  = 1'b0;
      m_done = 1'b0;
      if (m_beats_left > 0) begin
        if ((m_grant == 0) ? req0_valid : req1_valid) begin
          m_ena  = 1'b1;
          m_data = (m_grant == 0) ? req0_data : req1_data;
          m_beats_left--;
          if (m_beats_left == 0) m_quiet = DRAIN_CYCLES;
        end
      end else if (m_quiet > 0) begin
        m_quiet--;
        if (m_quiet == 0) begin
          m_done   = 1'b1;
          m_prefer = 1 - m_grant;
        end
      end else if (req0_valid || req1_valid) begin
        if (m_prefer == 0) m_grant = req0_valid ? 0 : 1;
        else               m_grant = req1_valid ? 1 : 0;
        m_beats_left = BURST_LEN;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("req0_ready", req0_ready, modelReady(0));
    checkOutput("req1_ready", req1_ready, modelReady(1));
    checkOutput("buf_ena",    buf_ena,    m_ena);
    checkOutput("buf_data",   buf_data,   m_data);
    checkOutput("grant_id",   grant_id,   m_grant);
    checkOutput("busy",       busy,       (m_beats_left > 0) || (m_quiet > 0));
    checkOutput("burst_done", burst_done, m_done);
  endtask

  // Drives one cycle of inputs, lets the model and DUT take the edge, then
  // compares just after the edge.
  task automatic applyStimulus(input logic r, input logic v0, input logic [3:0] d0,
                               input logic v1, input logic [3:0] d1);
    rst        = r;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  initial begin
    int seq;
    int stall_left;
    int ena_count;
    int done_count;
    logic prev_busy;
    logic acc;
    logic v0;
    logic v1;
    int grants[$];

    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 4'h0; req1_data = 4'h0;

    $display("[TB] reset with both requesters valid");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 4'h5, 1'b1, 4'h6);
    checkOutput("reset_buf_ena", buf_ena, 0);
    checkOutput("reset_ready0", req0_ready, 0);

    $display("[TB] single burst from req0");
    seq = 0; ena_count = 0; done_count = 0;
    for (int i = 0; i < 20; i++) begin
      v0  = (seq < 3);
      acc = modelReady(0) && v0;
      applyStimulus(1'b0, v0, 4'(seq), 1'b0, 4'h0);
      if (acc) seq++;
      ena_count  += int'(buf_ena);
      done_count += int'(burst_done);
    end
    checkOutput("single_accepted", seq, 3);
    checkOutput("single_ena_count", ena_count, 3);
    checkOutput("single_done_count", done_count, 1);

    $display("[TB] contention");
    applyStimulus(1'b1, 1'b1, 4'h4, 1'b1, 4'h8);
    prev_busy = 1'b0;
    grants.delete();
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b0, 1'b1, 4'h4, 1'b1, 4'h8);
      if (busy && !prev_busy) grants.push_back(int'(grant_id));
      prev_busy = busy;
    end
    checkOutput("contention_bursts", grants.size() >= 3, 1);
    if (grants.size() >= 3) begin
      checkOutput("contention_grant0", grants[0], 0);
      checkOutput("contention_grant1", grants[1], 1);
      checkOutput("contention_grant2", grants[2], 0);
    end

    $display("[TB] stall in the middle of a burst");
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    seq = 0; stall_left = 5; ena_count = 0;
    for (int i = 0; i < 30; i++) begin
      if (seq == 2 && stall_left > 0) begin
        v0 = 1'b0;
        stall_left--;
      end else begin
        v0 = (seq < 3);
      end
      acc = modelReady(0) && v0;
      applyStimulus(1'b0, v0, 4'(8 + seq), 1'b0, 4'h0);
      if (acc) seq++;
      ena_count += int'(buf_ena);
    end
    checkOutput("stall_accepted", seq, 3);
    checkOutput("stall_ena_count", ena_count, 3);

    $display("[TB] reset during a burst");
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    seq = 0;
    for (int i = 0; i < 10 && seq < 1; i++) begin
      acc = modelReady(0);
      applyStimulus(1'b0, 1'b1, 4'h3, 1'b0, 4'h0);
      if (acc) seq++;
    end
    checkOutput("abort_first_beat", seq, 1);
    applyStimulus(1'b1, 1'b1, 4'h3, 1'b0, 4'h0);
    seq = 0; ena_count = 0; done_count = 0;
    for (int i = 0; i < 25; i++) begin
      v0  = (seq < 3);
      acc = modelReady(0) && v0;
      applyStimulus(1'b0, v0, 4'(seq + 1), 1'b0, 4'h0);
      if (acc) seq++;
      ena_count  += int'(buf_ena);
      done_count += int'(burst_done);
    end
    checkOutput("abort_ena_count", ena_count, 3);
    checkOutput("abort_done_count", done_count, 1);

    $display("[TB] lockout of a late requester");
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    seq = 0; v1 = 1'b0; prev_busy = 1'b0;
    grants.delete();
    for (int i = 0; i < 40; i++) begin
      if (m_quiet > 0) v1 = 1'b1;
      v0  = (seq < 3);
      acc = modelReady(0) && v0;
      applyStimulus(1'b0, v0, 4'hC, v1, 4'hD);
      if (acc) seq++;
      if (busy && !prev_busy) grants.push_back(int'(grant_id));
      prev_busy = busy;
    end
    checkOutput("lockout_bursts", grants.size() >= 2, 1);
    if (grants.size() >= 2) begin
      checkOutput("lockout_grant0", grants[0], 0);
      checkOutput("lockout_grant1", grants[1], 1);
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0,
                    $urandom_range(0, 9) < 7, 4'($urandom),
                    $urandom_range(0, 9) < 7, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
